// File: rtl/pll_rst_gen.sv
// pll_rst_gen: staged reset release after a stable, synchronized PLL lock
module pll_rst_gen #(
  parameter int LOCK_WAIT = 1024,
  parameter int STAGE_GAP = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_lock,
  input  logic       soft_rst_req,
  output logic [2:0] stage_rst_n,
  output logic       sys_ready,
  output logic [7:0] lock_loss_cnt
);
  typedef enum logic [1:0] {WAIT_LOCK, REL0, REL1, RUN} state_t;
  localparam logic [15:0] LW_END = 16'(LOCK_WAIT - 1);
  localparam logic [15:0] SG_END = 16'(STAGE_GAP - 1);
  state_t      state, state_nxt;
  logic [1:0]  sync;
  logic [15:0] cnt, cnt_nxt;
  logic        lock_s, loss;
  assign lock_s = sync[1];
  always_comb begin
    state_nxt = state;
    cnt_nxt = cnt + 16'd1;
    loss = (state != WAIT_LOCK) && !lock_s;
    if (!lock_s || soft_rst_req) begin
      state_nxt = WAIT_LOCK;
      cnt_nxt = '0;
    end else if (state == WAIT_LOCK && cnt == LW_END) begin
      state_nxt = REL0;
      cnt_nxt = '0;
    end else if (state == REL0 && cnt == SG_END) begin
      state_nxt = REL1;
      cnt_nxt = '0;
    end else if (state == REL1 && cnt == SG_END) begin
      state_nxt = RUN;
      cnt_nxt = '0;
    end else if (state == RUN) begin
      cnt_nxt = cnt;
    end
  end
  // outputs are registered from the next state so they change on the transition edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
      state <= WAIT_LOCK;
      cnt <= '0;
      stage_rst_n <= '0;
      sys_ready <= 1'b0;
      lock_loss_cnt <= '0;
    end else begin
      sync <= {sync[0], pll_lock};
      state <= state_nxt;
      cnt <= cnt_nxt;
      stage_rst_n <= state_nxt == RUN ? 3'b111 : state_nxt == REL1 ? 3'b011 :
                     state_nxt == REL0 ? 3'b001 : 3'b000;
      sys_ready <= state_nxt == RUN;
      if (loss && lock_loss_cnt != 8'hff) lock_loss_cnt <= lock_loss_cnt + 8'd1;
    end
  end
endmodule

// File: doc/pll_rst_gen.md
PLL_RST_GEN -- requirements
Module: pll_rst_gen

Interface
REQ-001 The block SHALL have parameter LOCK_WAIT, default 1024, meaning the number of consecutive synchronized-lock cycles required before the first reset release (legal range 2..65535).
REQ-002 The block SHALL have parameter STAGE_GAP, default 64, meaning the number of cycles between successive stage releases (legal range 2..65535).
REQ-003 The block SHALL have port clk, input, 1 bit: the single free-running reference clock, which is the same clock as the PLL input (clkin1).
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port pll_lock, input, 1 bit: the PLL lock flag, asynchronous to clk.
REQ-006 The block SHALL have port soft_rst_req, input, 1 bit: synchronous software reset request, active high, level or pulse.
REQ-007 The block SHALL have port stage_rst_n, output, 3 bits: active-low reset per downstream domain; bit 0 is released first and bit 2 last.
REQ-008 The block SHALL have port sys_ready, output, 1 bit: high only when all three stages are released.
REQ-009 The block SHALL have port lock_loss_cnt, output, 8 bits: saturating count of lock-loss events.

Function
REQ-010 pll_lock SHALL pass through a 2-flop synchronizer before any use; the synchronizer output is lock_s.
REQ-011 The FSM SHALL have states WAIT_LOCK, REL0, REL1 and RUN, with one 16-bit cycle counter cnt.
REQ-012 In WAIT_LOCK: all stage_rst_n bits = 0; cnt is cleared whenever lock_s = 0 and increments whenever lock_s = 1.
REQ-013 In WAIT_LOCK, when lock_s = 1 and cnt = LOCK_WAIT-1, the FSM SHALL go to REL0, set stage_rst_n[0] = 1 and clear cnt.
REQ-014 In REL0, when cnt = STAGE_GAP-1, the FSM SHALL go to REL1, set stage_rst_n[1] = 1 and clear cnt.
REQ-015 In REL1, when cnt = STAGE_GAP-1, the FSM SHALL go to RUN, set stage_rst_n[2] = 1 and sys_ready = 1 on the same edge.
REQ-016 RUN SHALL be held indefinitely while lock_s = 1 and soft_rst_req = 0.
REQ-017 In any state other than WAIT_LOCK, lock_s = 0 SHALL, on the next edge, drive stage_rst_n = 3'b000, sys_ready = 0, cnt = 0 and state WAIT_LOCK, and increment lock_loss_cnt.
REQ-018 lock_loss_cnt SHALL saturate at 255 and never wrap.
REQ-019 lock_s = 0 while in WAIT_LOCK SHALL only clear cnt and SHALL NOT increment lock_loss_cnt.
REQ-020 soft_rst_req = 1 in any state SHALL have the same effect as REQ-017, except that lock_loss_cnt is not incremented.
REQ-021 While soft_rst_req is held high, the FSM SHALL stay in WAIT_LOCK with cnt = 0.
REQ-022 If lock_s = 0 and soft_rst_req = 1 on the same cycle outside WAIT_LOCK, the event SHALL be counted as a lock loss (single increment).
REQ-023 Latency from pll_lock falling to stage_rst_n = 0 SHALL be at most 3 clk edges (2 synchronizer edges + 1 register edge).
REQ-024 Latency from pll_lock rising, sampled high at edge 1, to stage_rst_n[0] rising SHALL be edge LOCK_WAIT+2.
REQ-025 stage_rst_n[k+1] SHALL rise exactly STAGE_GAP edges after stage_rst_n[k].
REQ-026 All outputs SHALL be registered; stage_rst_n bits SHALL only ever rise in order 0, 1, 2, and SHALL fall together.
REQ-027 A lock glitch shorter than 2 cycles that is not captured by the synchronizer SHALL have no effect.
REQ-028 A glitch that is captured SHALL restart the full LOCK_WAIT sequence.

Reset
REQ-029 rst_n = 0 SHALL asynchronously force: synchronizer flops = 0, state = WAIT_LOCK, cnt = 0, stage_rst_n = 3'b000, sys_ready = 0, lock_loss_cnt = 0.
REQ-030 Deassertion of rst_n mid-sequence SHALL restart from WAIT_LOCK; no partial release survives reset.

Verification (LOCK_WAIT=8, STAGE_GAP=4, pll_lock driven just after clk edges)
REQ-031 Bench SHALL drive pll_lock high from edge 0 -> stage_rst_n = 001 at edge 10, 011 at edge 14, 111 with sys_ready = 1 at edge 18.
REQ-032 Bench SHALL drive pll_lock low for 1 cycle at edge 6 of the lock-wait -> no release at edge 10; stage_rst_n[0] rises 8 edges after lock_s returns high; lock_loss_cnt = 0.
REQ-033 Bench SHALL drop pll_lock in RUN -> stage_rst_n = 000 and sys_ready = 0 within 3 edges; lock_loss_cnt = 1; full resequence after relock.
REQ-034 Bench SHALL pulse soft_rst_req for 1 cycle in RUN -> all resets asserted next edge; lock_loss_cnt unchanged; stage_rst_n = 111 again 8+8 edges later.
REQ-035 Bench SHALL apply 300 lock-loss events -> lock_loss_cnt = 255 and held there.
REQ-036 Bench SHALL assert rst_n low during REL1 -> outputs immediately 000 / sys_ready = 0 / lock_loss_cnt = 0; sequence restarts from WAIT_LOCK after release.
